// File: rtl/bit_unpacker.sv
// bit_unpacker: MSB-first variable-length field extractor for the compressed stream.
// Packed words are appended behind the valid bits of an MSB-aligned bit buffer;
// field requests remove bits from the top with a left funnel shift.
// Optional feature macro: BIT_UNPACKER_ALIGN_EN adds i_align, an internal pop that
// skips forward to the next byte boundary of the consumed-bit count.
module bit_unpacker #(
  parameter int IN_W    = 32,
  parameter int BUF_W   = 64,
  parameter int MAX_LEN = 32,
  parameter int LEN_BIT = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_in_valid,
  input  logic [IN_W-1:0]    i_in_word,
  output logic               o_in_ready,
  input  logic               i_req_valid,
  input  logic [LEN_BIT-1:0] i_req_len,
  output logic               o_req_ready,
`ifdef BIT_UNPACKER_ALIGN_EN
  input  logic               i_align,
`endif
  output logic               o_field_valid,
  output logic [MAX_LEN-1:0] o_field,
  output logic [LEN_BIT:0]   o_level,
  output logic               o_err
);

  localparam logic [LEN_BIT:0]   CNT_PUSH_MAX = (LEN_BIT+1)'(BUF_W - IN_W);
  localparam logic [LEN_BIT:0]   CNT_IN_W     = (LEN_BIT+1)'(IN_W);
  localparam logic [LEN_BIT:0]   CNT_MAX_LEN  = (LEN_BIT+1)'(MAX_LEN);
  localparam logic [LEN_BIT-1:0] LEN_MAX      = LEN_BIT'(MAX_LEN);

  logic [BUF_W-1:0]   r_buf;
  logic [LEN_BIT:0]   r_cnt;
  logic               r_field_valid;
  logic [MAX_LEN-1:0] r_field;
  logic               r_err;

  logic               w_len_ok;
  logic               w_push;
  logic               w_pop;
  logic [LEN_BIT-1:0] w_len;
  logic [LEN_BIT:0]   w_len_ext;
  logic [BUF_W-1:0]   w_in_aligned;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [LEN_BIT:0]   w_cnt_nxt;
  logic [MAX_LEN-1:0] w_top;
  logic [MAX_LEN-1:0] w_field;

`ifdef BIT_UNPACKER_ALIGN_EN
  logic [2:0] r_pos;
  logic [2:0] w_align_amt;
  logic       w_align_pop;
`endif

  assign w_len_ok    = (i_req_len <= LEN_MAX);
  assign o_in_ready  = !i_flush && (r_cnt <= CNT_PUSH_MAX);
  assign o_req_ready = !i_flush && w_len_ok && ({1'b0, i_req_len} <= r_cnt);
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = i_req_valid && o_req_ready;

`ifdef BIT_UNPACKER_ALIGN_EN
  // (8 - r_pos) % 8 is the 3-bit two's complement of r_pos
  assign w_align_amt = 3'd0 - r_pos;
  assign w_align_pop = i_align && !i_req_valid && !i_flush &&
                       ({{(LEN_BIT-2){1'b0}}, w_align_amt} <= r_cnt);
`endif

  // Select the number of bits removed this cycle (0 when nothing pops)
  always_comb begin
    w_len = '0;
    if (w_pop) begin
      w_len = i_req_len;
    end
`ifdef BIT_UNPACKER_ALIGN_EN
    else if (w_align_pop) begin
      w_len = {{(LEN_BIT-3){1'b0}}, w_align_amt};
    end
`endif
  end

  assign w_len_ext = {1'b0, w_len};

  // Pop consumes the old bits first; the new word lands right behind what remains
  assign w_in_aligned = {i_in_word, {(BUF_W-IN_W){1'b0}}} >> (r_cnt - w_len_ext);
  assign w_buf_nxt    = (r_buf << w_len) | (w_push ? w_in_aligned : '0);
  assign w_cnt_nxt    = r_cnt - w_len_ext + (w_push ? CNT_IN_W : '0);

  // Field taken from the pre-update buffer, right-aligned; L=0 shifts everything out
  assign w_top   = r_buf[BUF_W-1 -: MAX_LEN];
  assign w_field = w_top >> (CNT_MAX_LEN - {1'b0, i_req_len});

  // Buffer, level, result and sticky error registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf         <= '0;
      r_cnt         <= '0;
      r_field_valid <= 1'b0;
      r_field       <= '0;
      r_err         <= 1'b0;
`ifdef BIT_UNPACKER_ALIGN_EN
      r_pos         <= '0;
`endif
    end else begin
      if (i_flush) begin
        r_buf <= '0;
        r_cnt <= '0;
      end else begin
        r_buf <= w_buf_nxt;
        r_cnt <= w_cnt_nxt;
      end
`ifdef BIT_UNPACKER_ALIGN_EN
      if (i_flush) begin
        r_pos <= '0;
      end else begin
        r_pos <= r_pos + w_len[2:0];
      end
`endif
      r_field_valid <= w_pop;
      if (w_pop) begin
        r_field <= w_field;
      end
      if (i_req_valid && !w_len_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_field_valid = r_field_valid;
  assign o_field       = r_field;
  assign o_level       = r_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_bit_unpacker.sv
// Directed bench for bit_unpacker with hand-computed expected values.
// Define BIT_UNPACKER_ALIGN_EN for both files to exercise the align feature.
module tb_bit_unpacker;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_flush;
  logic        i_in_valid;
  logic [31:0] i_in_word;
  logic        o_in_ready;
  logic        i_req_valid;
  logic [5:0]  i_req_len;
  logic        o_req_ready;
`ifdef BIT_UNPACKER_ALIGN_EN
  logic        i_align;
`endif
  logic        o_field_valid;
  logic [31:0] o_field;
  logic [6:0]  o_level;
  logic        o_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit_unpacker #(
    .IN_W(32),
    .BUF_W(64),
    .MAX_LEN(32),
    .LEN_BIT(6)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_flush(i_flush),
    .i_in_valid(i_in_valid),
    .i_in_word(i_in_word),
    .o_in_ready(o_in_ready),
    .i_req_valid(i_req_valid),
    .i_req_len(i_req_len),
    .o_req_ready(o_req_ready),
`ifdef BIT_UNPACKER_ALIGN_EN
    .i_align(i_align),
`endif
    .o_field_valid(o_field_valid),
    .o_field(o_field),
    .o_level(o_level),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; sample 1ns after the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_flush     = 1'b0;
    i_in_valid  = 1'b0;
    i_req_valid = 1'b0;
    i_req_len   = '0;
`ifdef BIT_UNPACKER_ALIGN_EN
    i_align     = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input string tag, input logic [6:0] lvl);
    i_in_valid = 1'b1;
    i_in_word  = w;
    #1;
    check({tag, "_in_ready"}, o_in_ready, 1'b1);
    tick();
    i_in_valid = 1'b0;
    check({tag, "_level"}, o_level, lvl);
  endtask

  task automatic pop(input logic [5:0] len, input string tag, input logic [31:0] fld, input logic [6:0] lvl);
    i_req_valid = 1'b1;
    i_req_len   = len;
    #1;
    check({tag, "_req_ready"}, o_req_ready, 1'b1);
    tick();
    i_req_valid = 1'b0;
    check({tag, "_valid"}, o_field_valid, 1'b1);
    check({tag, "_field"}, o_field, fld);
    check({tag, "_level"}, o_level, lvl);
  endtask

  initial begin
    i_in_word = '0;
    do_reset();
    check("rst_level", o_level, 7'd0);
    check("rst_valid", o_field_valid, 1'b0);
    check("rst_field", o_field, 32'h0);
    check("rst_err", o_err, 1'b0);
    check("rst_in_ready", o_in_ready, 1'b1);

    // basic pops: A, 5A
    push_word(32'hA5A5F00F, "p1", 7'd32);
    pop(6'd4, "pop4", 32'hA, 7'd28);
    pop(6'd8, "pop8", 32'h5A, 7'd20);
    tick();
    check("hold_valid", o_field_valid, 1'b0);
    check("hold_field", o_field, 32'h5A);

    // flush, then simultaneous push/pop at r_cnt=32
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush1_level", o_level, 7'd0);
    push_word(32'h12345678, "p2", 7'd32);
    i_in_valid  = 1'b1;
    i_in_word   = 32'hDEADBEEF;
    i_req_valid = 1'b1;
    i_req_len   = 6'd16;
    #1;
    check("pp_in_ready", o_in_ready, 1'b1);
    check("pp_req_ready", o_req_ready, 1'b1);
    tick();
    idle();
    check("pp_field", o_field, 32'h1234);
    check("pp_valid", o_field_valid, 1'b1);
    check("pp_level", o_level, 7'd48);
    #1;
    check("full_in_ready", o_in_ready, 1'b0);
    pop(6'd32, "pop32", 32'h5678DEAD, 7'd16);

    // underflow: leave 4 bits (F), request 8
    pop(6'd12, "pop12", 32'hBEE, 7'd4);
    i_req_valid = 1'b1;
    i_req_len   = 6'd8;
    #1;
    check("uf_req_ready", o_req_ready, 1'b0);
    tick();
    check("uf_valid", o_field_valid, 1'b0);
    check("uf_level", o_level, 7'd4);
    i_in_valid = 1'b1;
    i_in_word  = 32'h12345678;
    #1;
    check("uf_req_ready2", o_req_ready, 1'b0);
    tick();
    i_in_valid = 1'b0;
    check("uf_valid2", o_field_valid, 1'b0);
    check("uf_level2", o_level, 7'd36);
    #1;
    check("uf_req_ready3", o_req_ready, 1'b1);
    tick();
    i_req_valid = 1'b0;
    check("uf_valid3", o_field_valid, 1'b1);
    check("uf_field", o_field, 32'hF1);
    check("uf_level3", o_level, 7'd28);

    // illegal length, then zero-length pop
    i_req_valid = 1'b1;
    i_req_len   = 6'd33;
    #1;
    check("ill_req_ready", o_req_ready, 1'b0);
    tick();
    i_req_valid = 1'b0;
    check("ill_err", o_err, 1'b1);
    check("ill_valid", o_field_valid, 1'b0);
    check("ill_level", o_level, 7'd28);
    pop(6'd0, "pop0", 32'h0, 7'd28);
    check("err_sticky", o_err, 1'b1);

    // flush at level 40 with push and pop pending
    pop(6'd20, "pop20", 32'h23456, 7'd8);
    push_word(32'hCAFEF00D, "p3", 7'd40);
    i_flush     = 1'b1;
    i_in_valid  = 1'b1;
    i_in_word   = 32'h11111111;
    i_req_valid = 1'b1;
    i_req_len   = 6'd8;
    #1;
    check("fl_in_ready", o_in_ready, 1'b0);
    check("fl_req_ready", o_req_ready, 1'b0);
    tick();
    idle();
    check("fl_level", o_level, 7'd0);
    check("fl_valid", o_field_valid, 1'b0);
    check("fl_field", o_field, 32'h23456);

    // reset mid-stream
    push_word(32'h87654321, "p4", 7'd32);
    i_req_valid = 1'b1;
    i_req_len   = 6'd4;
    tick();
    check("mid_field", o_field, 32'h8);
    i_reset    = 1'b1;
    i_in_valid = 1'b1;
    i_in_word  = 32'hFFFFFFFF;
    tick();
    check("mr_level", o_level, 7'd0);
    check("mr_valid", o_field_valid, 1'b0);
    check("mr_field", o_field, 32'h0);
    check("mr_err", o_err, 1'b0);
    i_reset = 1'b0;
    idle();

`ifdef BIT_UNPACKER_ALIGN_EN
    // consume 3 bits, align drops 5 more, next byte is A5
    push_word(32'hA5A5F00F, "ap", 7'd32);
    pop(6'd3, "apop3", 32'h5, 7'd29);
    i_align = 1'b1;
    tick();
    i_align = 1'b0;
    check("al_valid", o_field_valid, 1'b0);
    check("al_level", o_level, 7'd24);
    pop(6'd8, "apop8", 32'hA5, 7'd16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
